wave_ram_arbiter: RTL

WAVE_RAM_ARBITER -- requirements
Module: wave_ram_arbiter

---
 rtl/wave_ram_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/wave_ram_arbiter.sv
// Wave RAM arbiter: shares a single-port 16-byte wave RAM between the CPU
// (FF30-FF3F) and the channel 3 sample fetcher. Each RAM cycle is a
// precharge phase followed by an access phase. CH3 has priority. While CH3
// plays, the CPU only reaches the RAM shortly after a CH3 access.
module wave_ram_arbiter #(
   parameter int CPU_WINDOW = 2
) (
   input  logic       cclk,
   input  logic       reset,
   input  logic       cpu_sel,
   input  logic [3:0] cpu_a,
   input  logic       soc_rd,
   input  logic       soc_wr,
   input  logic [7:0] cpu_wd,
   input  logic       ch3_active,
   input  logic       ch3_fetch,
   input  logic [4:0] ch3_pos,
   input  logic [7:0] wave_rd,
   output logic [3:0] wave_a,
   output logic [7:0] wave_wd,
   output logic       n_wave_rd,
   output logic       n_wave_wr,
   output logic       wave_bl_pch,
   output logic [3:0] ch3_sample,
   output logic [7:0] cpu_rd_data,
   output logic       cpu_rd_valid,
   output logic       busy
);

   localparam int WIN_MAX = CPU_WINDOW + 1;
   localparam int WIN_W   = $clog2(WIN_MAX + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PCH = 2'd1, S_ACC = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             req_prev_q;
   logic             cpu_pend_q, cpu_pend_d;
   logic             cpu_rd_q, cpu_rd_d;
   logic [3:0]       cpu_a_q, cpu_a_d;
   logic [7:0]       cpu_wd_q, cpu_wd_d;
   logic             ch3_pend_q, ch3_pend_d;
   logic [4:0]       ch3_pos_q, ch3_pos_d;
   logic             gnt_ch3_q, gnt_ch3_d;
   logic             gnt_rd_q, gnt_rd_d;
   logic             gnt_lo_q, gnt_lo_d;
   logic [3:0]       wave_a_q, wave_a_d;
   logic [7:0]       wave_wd_q, wave_wd_d;
   logic [3:0]       last_idx_q, last_idx_d;
   logic [3:0]       ch3_sample_q, ch3_sample_d;
   logic [7:0]       cpu_rd_data_q, cpu_rd_data_d;
   logic             cpu_rd_valid_q, cpu_rd_valid_d;
   logic [WIN_W-1:0] win_q, win_d;

   logic cpu_req, cpu_edge, ch3_acc, in_window, cpu_inflight;
   logic cpu_accept, cpu_reject, ch3_new, cpu_pend_eff, ch3_pend_eff;
   logic grant_ch3, grant_cpu;

   // Request capture: edge detect, window test, and the latched request fields.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      cpu_req      = cpu_sel & (soc_rd | soc_wr);
      cpu_edge     = cpu_req & ~req_prev_q;
      ch3_acc      = (state_q == S_ACC) & gnt_ch3_q;
      in_window    = ch3_acc | (win_q <= WIN_W'(CPU_WINDOW));
      cpu_inflight = (state_q != S_IDLE) & ~gnt_ch3_q;
      cpu_accept   = cpu_edge & ~cpu_pend_q & (~ch3_active | in_window);
      cpu_reject   = cpu_edge & ~cpu_pend_q & ~cpu_inflight & ch3_active & ~in_window;
      ch3_new      = ch3_fetch & ch3_active;
      cpu_pend_eff = cpu_pend_q | cpu_accept;
      ch3_pend_eff = ch3_pend_q | ch3_new;
      // A request arriving this cycle is visible to the arbiter immediately.
      cpu_rd_d     = cpu_accept ? soc_rd : cpu_rd_q;
      cpu_a_d      = cpu_accept ? (ch3_active ? last_idx_q : cpu_a) : cpu_a_q;
      cpu_wd_d     = cpu_accept ? cpu_wd : cpu_wd_q;
      ch3_pos_d    = ch3_new ? ch3_pos : ch3_pos_q;
   end

   // Arbiter FSM next state: CH3 wins over CPU whenever a new RAM cycle starts.
   always_comb begin
      state_d   = state_q;
      grant_ch3 = 1'b0;
      grant_cpu = 1'b0;
      case (state_q)
         S_IDLE, S_ACC: begin
            if (ch3_pend_eff) begin
               grant_ch3 = 1'b1;
               state_d   = S_PCH;
            end else if (cpu_pend_eff) begin
               grant_cpu = 1'b1;
               state_d   = S_PCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PCH:   state_d = S_ACC;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next state: grant bookkeeping, end-of-access capture, window count.
   always_comb begin
      cpu_pend_d     = cpu_pend_eff & ~grant_cpu;
      ch3_pend_d     = ch3_pend_eff & ~grant_ch3;
      gnt_ch3_d      = gnt_ch3_q;
      gnt_rd_d       = gnt_rd_q;
      gnt_lo_d       = gnt_lo_q;
      wave_a_d       = wave_a_q;
      wave_wd_d      = wave_wd_q;
      last_idx_d     = last_idx_q;
      ch3_sample_d   = ch3_sample_q;
      cpu_rd_data_d  = cpu_rd_data_q;
      cpu_rd_valid_d = 1'b0;
      if (grant_ch3) begin
         gnt_ch3_d = 1'b1;
         gnt_rd_d  = 1'b1;
         gnt_lo_d  = ch3_pos_d[0];
         wave_a_d  = ch3_pos_d[4:1];
      end else if (grant_cpu) begin
         gnt_ch3_d = 1'b0;
         gnt_rd_d  = cpu_rd_d;
         wave_a_d  = cpu_a_d;
         if (!cpu_rd_d) wave_wd_d = cpu_wd_d;
      end
      if (state_q == S_ACC) begin
         if (gnt_ch3_q) begin
            last_idx_d   = wave_a_q;
            ch3_sample_d = gnt_lo_q ? wave_rd[3:0] : wave_rd[7:4];
         end else if (gnt_rd_q) begin
            cpu_rd_data_d  = wave_rd;
            cpu_rd_valid_d = 1'b1;
         end
      end
      // A locked-out read answers with open-bus data without touching the RAM.
      if (cpu_reject && soc_rd) begin
         cpu_rd_data_d  = 8'hFF;
         cpu_rd_valid_d = 1'b1;
      end
      if (ch3_acc)                         win_d = WIN_W'(1);
      else if (win_q == WIN_W'(WIN_MAX))   win_d = win_q;
      else                                 win_d = win_q + WIN_W'(1);
   end

   // State registers; reset abandons any access and reopens nothing.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge cclk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         req_prev_q     <= 1'b0;
         cpu_pend_q     <= 1'b0;
         cpu_rd_q       <= 1'b0;
         cpu_a_q        <= 4'd0;
         cpu_wd_q       <= 8'd0;
         ch3_pend_q     <= 1'b0;
         ch3_pos_q      <= 5'd0;
         gnt_ch3_q      <= 1'b0;
         gnt_rd_q       <= 1'b0;
         gnt_lo_q       <= 1'b0;
         wave_a_q       <= 4'd0;
         wave_wd_q      <= 8'd0;
         last_idx_q     <= 4'd0;
         ch3_sample_q   <= 4'd0;
         cpu_rd_data_q  <= 8'd0;
         cpu_rd_valid_q <= 1'b0;
         win_q          <= WIN_W'(WIN_MAX);
      end else begin
         state_q        <= state_d;
         req_prev_q     <= cpu_req;
         cpu_pend_q     <= cpu_pend_d;
         cpu_rd_q       <= cpu_rd_d;
         cpu_a_q        <= cpu_a_d;
         cpu_wd_q       <= cpu_wd_d;
         ch3_pend_q     <= ch3_pend_d;
         ch3_pos_q      <= ch3_pos_d;
         gnt_ch3_q      <= gnt_ch3_d;
         gnt_rd_q       <= gnt_rd_d;
         gnt_lo_q       <= gnt_lo_d;
         wave_a_q       <= wave_a_d;
         wave_wd_q      <= wave_wd_d;
         last_idx_q     <= last_idx_d;
         ch3_sample_q   <= ch3_sample_d;
         cpu_rd_data_q  <= cpu_rd_data_d;
         cpu_rd_valid_q <= cpu_rd_valid_d;
         win_q          <= win_d;
      end
   end

   assign wave_bl_pch  = (state_q == S_PCH);
   assign n_wave_rd    = ~((state_q == S_ACC) & gnt_rd_q);
   assign n_wave_wr    = ~((state_q == S_ACC) & ~gnt_rd_q);
   assign busy         = (state_q != S_IDLE) | cpu_pend_q | ch3_pend_q;
   assign wave_a       = wave_a_q;
   assign wave_wd      = wave_wd_q;
   assign ch3_sample   = ch3_sample_q;
   assign cpu_rd_data  = cpu_rd_data_q;
   assign cpu_rd_valid = cpu_rd_valid_q;

endmodule
